// File: rtl/regfile_sequencer_pkg.sv
// Shared types and helpers for the register-bank load/dump sequencer.
package regfile_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DUMP_ADDR,
    DUMP_OUT,
    DONE
  } seq_state_t;

  function automatic int unsigned last_addr(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/regfile_sequencer_if.sv
// Stream and register-bank signals of the sequencer.
// master is the sequencer view; slave is the host/bank view.
interface regfile_sequencer_if #(
  parameter int N = 4,
  parameter int W = 16
);
  logic         start_load;
  logic         start_dump;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [N-1:0] out_addr;
  logic         out_ready;
  logic         rf_we;
  logic [N-1:0] rf_addr_rd;
  logic [W-1:0] rf_data_in;
  logic [N-1:0] rf_addr_rs1;
  logic [W-1:0] rf_rs1;
  logic         busy;
  logic         done;

  modport master (
    input  start_load, start_dump, in_valid, in_data, out_ready, rf_rs1,
    output in_ready, out_valid, out_data, out_addr,
           rf_we, rf_addr_rd, rf_data_in, rf_addr_rs1, busy, done
  );

  modport slave (
    output start_load, start_dump, in_valid, in_data, out_ready, rf_rs1,
    input  in_ready, out_valid, out_data, out_addr,
           rf_we, rf_addr_rd, rf_data_in, rf_addr_rs1, busy, done
  );
endinterface

// File: rtl/regfile_sequencer.sv
// Bulk load/dump controller: streams words into registers 1..2^N-1 and
// streams them back out tagged with their address. Register 0 is never touched.
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  regfile_sequencer_if.master bus
);

  localparam logic [N-1:0] FIRST = N'(1);
  localparam logic [N-1:0] LAST  = N'(last_addr(N));

  seq_state_t   state_q, state_d;
  logic [N-1:0] addr_q, addr_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [N-1:0] out_addr_q, out_addr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= FIRST;
      out_data_q <= '0;
      out_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    unique case (state_q)
      IDLE: begin
        // Load has priority when both starts arrive together.
        if (bus.start_load) begin
          state_d = LOAD;
          addr_d  = FIRST;
        end else if (bus.start_dump) begin
          state_d = DUMP_ADDR;
          addr_d  = FIRST;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          if (addr_q == LAST) state_d = DONE;
          else                addr_d  = addr_q + 1'b1;
        end
      end
      DUMP_ADDR: begin
        // The bank read is combinational, so rs1 is valid for capture now.
        out_data_d = bus.rf_rs1;
        out_addr_d = addr_q;
        state_d    = DUMP_OUT;
      end
      DUMP_OUT: begin
        if (bus.out_ready) begin
          if (addr_q == LAST) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = DUMP_ADDR;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready    = 1'b0;
    bus.rf_we       = 1'b0;
    bus.rf_addr_rd  = '0;
    bus.rf_addr_rs1 = '0;
    bus.out_valid   = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    unique case (state_q)
      LOAD: begin
        bus.in_ready   = 1'b1;
        bus.rf_we      = bus.in_valid;
        bus.rf_addr_rd = addr_q;
        bus.busy       = 1'b1;
      end
      DUMP_ADDR: begin
        bus.rf_addr_rs1 = addr_q;
        bus.busy        = 1'b1;
      end
      DUMP_OUT: begin
        bus.rf_addr_rs1 = addr_q;
        bus.out_valid   = 1'b1;
        bus.busy        = 1'b1;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.rf_data_in = bus.in_data;
  assign bus.out_data   = out_data_q;
  assign bus.out_addr   = out_addr_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed/randomized bench for regfile_sequencer with a behavioural register bank.
module tb_regfile_sequencer;

  localparam int N = 4;
  localparam int W = 16;
  localparam int NREG = 1 << N;
  localparam int LASTR = NREG - 1;

  logic clk;
  logic rst;
  logic bank_init;
  int   checks;
  int   errors;

  logic [W-1:0] bank     [NREG];
  logic [W-1:0] model_rf [NREG];

  regfile_sequencer_if #(.N(N), .W(W)) bus ();

  regfile_sequencer #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bank_init) begin
      for (int i = 0; i < NREG; i++) bank[i] <= W'(16'hBAD0 + i);
    end else if (bus.rf_we) begin
      bank[bus.rf_addr_rd] <= bus.rf_data_in;
    end
  end
  assign bus.rf_rs1 = bank[bus.rf_addr_rs1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input bit full, input bit collide);
    int beats;
    logic [W-1:0] d;
    logic v;
    step();
    bus.start_load = 1'b1;
    bus.start_dump = collide;
    step();
    bus.start_load = 1'b0;
    bus.start_dump = 1'b0;
    beats = 0;
    for (int cyc = 0; cyc < 300 && beats < LASTR; cyc++) begin
      if (full) begin
        v = 1'b1;
        d = W'(16'h1000 + beats + 1);
      end else begin
        v = (cyc >= 4 && cyc < 7) ? 1'b0 : ($urandom_range(0, 3) != 0);
        d = W'($urandom);
        bus.start_dump = (cyc == 2);
      end
      bus.in_valid = v;
      bus.in_data  = d;
      #1;
      chk("load_in_ready", 32'(bus.in_ready), 1);
      chk("load_busy", 32'(bus.busy), 1);
      chk("load_done", 32'(bus.done), 0);
      chk("load_rf_we", 32'(bus.rf_we), 32'(v));
      chk("load_rf_addr_rd", 32'(bus.rf_addr_rd), beats + 1);
      chk("load_rf_data_in", 32'(bus.rf_data_in), 32'(d));
      step();
      if (v) begin
        beats++;
        model_rf[beats] = d;
      end
    end
    chk("load_beats", beats, LASTR);
    bus.in_valid   = 1'b0;
    bus.start_dump = 1'b0;
    #1;
    chk("load_end_done", 32'(bus.done), 1);
    chk("load_end_busy", 32'(bus.busy), 0);
    chk("load_end_in_ready", 32'(bus.in_ready), 0);
    chk("load_end_rf_we", 32'(bus.rf_we), 0);
    step();
    chk("load_idle_done", 32'(bus.done), 0);
    chk("load_idle_in_ready", 32'(bus.in_ready), 0);
    chk("bank_reg0", 32'(bank[0]), 32'(16'hBAD0));
    for (int i = 1; i < NREG; i++) chk("bank_contents", 32'(bank[i]), 32'(model_rf[i]));
  endtask

  task automatic do_dump(input int stop_at, input bit rand_bp, input int stall_word);
    int stall;
    step();
    bus.start_dump = 1'b1;
    step();
    bus.start_dump = 1'b0;
    for (int a = 1; a <= LASTR; a++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("dump_addr_out_valid", 32'(bus.out_valid), 0);
      chk("dump_addr_rs1", 32'(bus.rf_addr_rs1), a);
      chk("dump_addr_busy", 32'(bus.busy), 1);
      step();
      if (rand_bp)              stall = int'($urandom_range(0, 2));
      else if (a == stall_word) stall = 5;
      else                      stall = 0;
      for (int c = 0; c <= stall; c++) begin
        bus.out_ready = (c == stall) && (a != stop_at);
        #1;
        chk("dump_out_valid", 32'(bus.out_valid), 1);
        chk("dump_out_data", 32'(bus.out_data), 32'(model_rf[a]));
        chk("dump_out_addr", 32'(bus.out_addr), a);
        chk("dump_out_rs1", 32'(bus.rf_addr_rs1), a);
        chk("dump_out_done", 32'(bus.done), 0);
        if (a == stop_at) return;
        step();
      end
    end
    bus.out_ready = 1'b0;
    #1;
    chk("dump_end_done", 32'(bus.done), 1);
    chk("dump_end_busy", 32'(bus.busy), 0);
    chk("dump_end_out_valid", 32'(bus.out_valid), 0);
    chk("dump_end_rs1", 32'(bus.rf_addr_rs1), 0);
    step();
    chk("dump_idle_done", 32'(bus.done), 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_rf_we"}, 32'(bus.rf_we), 0);
    chk({tag, "_rf_addr_rd"}, 32'(bus.rf_addr_rd), 0);
    chk({tag, "_rf_addr_rs1"}, 32'(bus.rf_addr_rs1), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bank_init = 1'b1;
    bus.start_load = 1'b0;
    bus.start_dump = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    for (int i = 0; i < NREG; i++) model_rf[i] = W'(16'hBAD0 + i);

    step();
    step();
    chk_quiet("reset");
    chk("reset_out_data", 32'(bus.out_data), 0);
    chk("reset_out_addr", 32'(bus.out_addr), 0);
    rst = 1'b0;
    bank_init = 1'b0;
    step();
    chk_quiet("post_reset");

    // Full sequential load with both starts colliding; load must win.
    do_load(1'b1, 1'b1);
    do_dump(0, 1'b0, 3);

    // Reset in the middle of a dump, while word 7 is being presented.
    do_dump(7, 1'b0, 0);
    #1;
    rst = 1'b1;
    #1;
    chk_quiet("async_reset");
    chk("async_reset_out_data", 32'(bus.out_data), 0);
    chk("async_reset_out_addr", 32'(bus.out_addr), 0);
    step();
    step();
    rst = 1'b0;
    step();
    chk_quiet("reset_release");
    do_dump(0, 1'b0, 0);

    // Random load with gaps and an ignored dump request.
    do_load(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk_quiet("no_queued_dump");
      step();
    end
    do_dump(0, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Bulk load/dump controller for the register bank.
- **Load:** accepts a valid/ready word stream and writes it into registers 1..2^N-1 through the bank's write port.
- **Dump:** reads registers 1..2^N-1 back through the bank's first read port and emits them as a valid/ready stream, each word tagged with its register address.
- **Placement:** sits between the test/host stream logic and the register bank. It is the only driver of the bank's write port and rs1 read address while busy.

## Interface
- `N`, default 4: register address bits. The bank has 2^N registers; register 0 is skipped.
- `W`, default 16: data word width in bits.
- `clk`  in  1: clock. Everything is sampled on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start_load`  in  1: begin a load; sampled only in IDLE.
- `start_dump`  in  1: begin a dump; sampled only in IDLE.
- `in_valid`  in  1: input word valid.
- `in_data`  in  W: input word.
- `in_ready`  out  1: sequencer accepts `in_data` this cycle.
- `out_valid`  out  1: output word valid.
- `out_data`  out  W: dumped register value.
- `out_addr`  out  N: register address of `out_data`.
- `out_ready`  in  1: consumer accepts the output word.
- `rf_we`  out  1: to bank `we`.
- `rf_addr_rd`  out  N: to bank `addr_rd`.
- `rf_data_in`  out  W: to bank `data_in`.
- `rf_addr_rs1`  out  N: to bank `addr_rs1`.
- `rf_rs1`  in  W: from bank `rs1` (combinational read).
- `busy`  out  1: high in LOAD, DUMP_ADDR and DUMP_OUT.
- `done`  out  1: one-cycle pulse when a load or dump completes.

## Operation
- **States:** IDLE, LOAD, DUMP_ADDR, DUMP_OUT, DONE. Enum `seq_state_t`.
- **Address counter `addr`:** N bits. Loaded with 1 on every start. Last address is LAST = 2^N-1 (all ones). Never wraps and never touches register 0.
- **IDLE:**
  - `start_load` → LOAD.
  - Otherwise `start_dump` → DUMP_ADDR.
  - Both high: load wins.
- **LOAD:**
  - `in_ready` = 1.
  - `rf_we` = `in_valid` (combinational); `rf_addr_rd` = `addr`; `rf_data_in` = `in_data`.
  - On each accepted beat (`in_valid & in_ready`): if `addr` == LAST → DONE, else `addr` increments.
  - Cycles with `in_valid` low leave `addr` unchanged and write nothing.
- **DUMP_ADDR:**
  - `rf_addr_rs1` = `addr`; `out_valid` = 0.
  - At the next edge: `out_data` ← `rf_rs1`, `out_addr` ← `addr`, → DUMP_OUT.
- **DUMP_OUT:**
  - `out_valid` = 1; `out_data` and `out_addr` held stable. `rf_addr_rs1` stays `addr`.
  - On `out_ready`: if `addr` == LAST → DONE, else `addr` increments → DUMP_ADDR.
- **DONE:** `done` = 1 for exactly one cycle → IDLE.
- **Start handling:** starts in any state other than IDLE are ignored, not queued.
- **Port defaults outside their states:**
  - `rf_we` = 0, `rf_addr_rd` = 0 and `rf_addr_rs1` = 0 outside LOAD / DUMP states respectively.
  - `rf_data_in` mirrors `in_data` unconditionally.
  - `in_ready` = 0 outside LOAD.
- **Reset:**
  - `rst` forces IDLE, `addr` = 1, `out_data` = 0 and `out_addr` = 0 immediately, without waiting for a clock edge.
  - All outputs read 0 during reset: `in_ready`, `out_valid`, `rf_we`, `busy`, `done`, addresses and data.
  - Reset mid-operation abandons the transfer. Registers already written keep their values; the bank's own reset is separate.
- **Data path:** widths are exact, with no arithmetic on data.

## Timing
- A start sampled high in IDLE at edge k gives `busy` = 1 and the new state from cycle k+1.
- **Load:**
  - One register write per accepted beat, committed at the edge where the beat is accepted.
  - Full load with continuous `in_valid`: 15 write cycles (N=4), then `done` in the following cycle.
- **Dump:**
  - 2 cycles per word minimum (DUMP_ADDR + DUMP_OUT), plus backpressure cycles.
  - First `out_valid` two cycles after the start edge.
- **Handshakes:**
  - Once `out_valid` rises, `out_valid`, `out_data` and `out_addr` must not change until `out_ready` is sampled high.
  - `in_ready` may be 1 while `in_valid` is 0; a beat is transferred only when both are high on an edge.
- `busy` falls in the same cycle `done` rises. `busy` and `done` are never both high.

## Structure
- **Shared package `regfile_seq_pkg`:**
  - `seq_state_t` enum.
  - Function `last_addr(N)` returning 2^N-1.
- **Sub-modules:** none. The address counter and FSM fit naturally in one module.
- **Bench top:** instantiates `regfile_sequencer` together with the existing register bank.
  - `rf_*` outputs connect straight to the bank.
  - `rf_rs1` is driven by the bank's `rs1`.

## Test plan
- **Full load:** `start_load`, then `in_data` 0x1001..0x100F with `in_valid` held high → `rf_we` high 15 consecutive cycles, `rf_addr_rd` 1..15, `done` one cycle after the last write, `in_ready` 0 afterwards.
- **Dump after load:** `start_dump` with `out_ready` = 1 → `out_data` 0x1001..0x100F with `out_addr` 1..15, one word every 2 cycles, `done` after word 15, register 0 never read.
- **Gaps and backpressure:** `in_valid` low for 3 cycles mid-load → no write, `addr` frozen. `out_ready` low 5 cycles on word 3 → `out_valid` stays 1, `out_data` = 0x1003 and `out_addr` = 3 stable.
- **Start collisions:** `start_load` and `start_dump` high together → load runs. `start_dump` pulsed during load → ignored, with no dump after `done`.
- **Reset mid-dump:** assert `rst` while `out_addr` = 7 → all outputs 0 before the next edge, state IDLE. A new dump after release restarts at `out_addr` = 1 with `out_data` 0x1001.
